// File: rtl/piso_ser8_pkg.sv
// -----------------------------------------------------------------------------
// piso_ser8_pkg
// Shared definitions for the parallel-in / serial-out serializer:
//   - PISO_WIDTH_DEFAULT : default word width
//   - state_t            : serializer FSM state encoding (IDLE / SHIFT)
// -----------------------------------------------------------------------------
package piso_ser8_pkg;

  localparam int unsigned PISO_WIDTH_DEFAULT = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage : piso_ser8_pkg

// File: rtl/piso_bitcnt.sv
// -----------------------------------------------------------------------------
// piso_bitcnt
// Bit counter for the serializer. It counts shifted bits within a frame and
// flags the last bit position.
// Ports:
//   clk  in   clock
//   Re   in   asynchronous active-low reset
//   clr  in   synchronous clear to 0 (has priority over inc)
//   inc  in   increment by one
//   cnt  out  current bit index, $clog2(WIDTH) bits
//   tc   out  terminal count, high when cnt == WIDTH-1
// -----------------------------------------------------------------------------
module piso_bitcnt
  import piso_ser8_pkg::*;
#(
  parameter  int unsigned WIDTH = PISO_WIDTH_DEFAULT,
  localparam int unsigned CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          Re,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge Re) begin
    if (!Re) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign cnt = r_cnt;
  assign tc  = (r_cnt == CW'(WIDTH - 1));

endmodule : piso_bitcnt

// File: rtl/piso_ser8.sv
// -----------------------------------------------------------------------------
// piso_ser8
// Parallel-in / serial-out serializer with a one-word holding register, so
// consecutive frames leave with no gap cycle.
// Ports:
//   clk        in   clock, rising edge
//   Re         in   asynchronous active-low reset
//   ld_valid   in   upstream offers ld_data
//   ld_data    in   WIDTH-bit word to serialize
//   ld_ready   out  a word can be accepted (NOT hold_full, registered only)
//   msb_first  in   bit order, captured with each accepted word
//   en         in   shift enable; 0 freezes the current frame
//   sOut       out  serial data bit (0 while idle)
//   sValid     out  sOut is valid this cycle (busy AND en)
//   frame_end  out  last bit of a frame is valid on sOut
//   busy       out  a frame occupies the shift register
// -----------------------------------------------------------------------------
module piso_ser8
  import piso_ser8_pkg::*;
#(
  parameter int unsigned WIDTH = PISO_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             Re,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_ready,
  input  logic             msb_first,
  input  logic             en,
  output logic             sOut,
  output logic             sValid,
  output logic             frame_end,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_sr;
  logic             r_sr_msb;
  logic [WIDTH-1:0] r_hr;
  logic             r_hr_msb;
  logic             r_hold_full;

  logic [CW-1:0]    w_cnt;
  logic             w_tc;
  logic             w_accept;
  logic             w_frame_end;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_sr_load_in;
  logic             w_sr_load_hr;
  logic             w_sr_shift;
  logic             w_hr_load;

  // ld_ready depends on registered state only, so upstream sees no
  // combinational loop through ld_valid.
  assign ld_ready    = ~r_hold_full;
  assign w_accept    = ld_valid & ~r_hold_full;
  assign busy        = (r_state == SHIFT);
  assign sValid      = busy & en;
  assign w_frame_end = sValid & w_tc;
  assign frame_end   = w_frame_end;
  assign sOut        = busy & (r_sr_msb ? r_sr[WIDTH-1] : r_sr[0]);

  piso_bitcnt #(
    .WIDTH (WIDTH)
  ) u_bitcnt (
    .clk (clk),
    .Re  (Re),
    .clr (w_cnt_clr),
    .inc (w_cnt_inc),
    .cnt (w_cnt),
    .tc  (w_tc)
  );

  always_ff @(posedge clk or negedge Re) begin
    if (!Re) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_sr_load_in = 1'b0;
    w_sr_load_hr = 1'b0;
    w_sr_shift   = 1'b0;
    w_hr_load    = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Word bypasses HR straight into SR; first bit appears next cycle.
        if (w_accept) begin
          w_sr_load_in = 1'b1;
          w_cnt_clr    = 1'b1;
          w_state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        if (w_frame_end) begin
          w_cnt_clr = 1'b1;
          if (r_hold_full) begin
            // ld_ready is low here, so HR cannot be refilled on this edge.
            w_sr_load_hr = 1'b1;
          end else if (w_accept) begin
            // A word arriving exactly at frame end with HR empty goes straight
            // into SR; parking it in HR while falling to IDLE would strand it.
            w_sr_load_in = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          if (en) begin
            w_sr_shift = 1'b1;
            w_cnt_inc  = 1'b1;
          end
          // HR may be filled even while the frame is stalled.
          if (w_accept) begin
            w_hr_load = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: SR and HR are ordinary flops, not a memory array, so they take the
  // asynchronous reset like any other state.
  always_ff @(posedge clk or negedge Re) begin
    if (!Re) begin
      r_sr        <= '0;
      r_sr_msb    <= 1'b0;
      r_hr        <= '0;
      r_hr_msb    <= 1'b0;
      r_hold_full <= 1'b0;
    end else begin
      if (w_sr_load_in) begin
        r_sr     <= ld_data;
        r_sr_msb <= msb_first;
      end else if (w_sr_load_hr) begin
        r_sr     <= r_hr;
        r_sr_msb <= r_hr_msb;
      end else if (w_sr_shift) begin
        // Shift toward whichever end currently drives sOut.
        r_sr <= r_sr_msb ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};
      end

      if (w_hr_load) begin
        r_hr        <= ld_data;
        r_hr_msb    <= msb_first;
        r_hold_full <= 1'b1;
      end else if (w_sr_load_hr) begin
        r_hold_full <= 1'b0;
      end
    end
  end

  // The counter is cleared on every frame end, so it always rests at 0 while idle.
  a_idle_cnt_zero : assert property (
    @(posedge clk) disable iff (!Re) (r_state == IDLE) |-> (w_cnt == '0)
  );

endmodule : piso_ser8

// File: tb/tb_piso_ser8.sv
// -----------------------------------------------------------------------------
// tb_piso_ser8
// Self-checking bench for piso_ser8. A queue of accepted words is the
// reference: the head word's bit index gives the expected sOut/frame_end,
// queue depth gives busy (>0) and ld_ready (<2).
// -----------------------------------------------------------------------------
module tb_piso_ser8;

  localparam int W = 8;

  logic         clk;
  logic         Re;
  logic         ld_valid;
  logic [W-1:0] ld_data;
  logic         ld_ready;
  logic         msb_first;
  logic         en;
  logic         sOut;
  logic         sValid;
  logic         frame_end;
  logic         busy;

  int n_cmp;
  int n_err;

  // reference model state
  logic [W-1:0] q_word[$];
  logic         q_msb[$];
  int           head_idx;
  int           n_acc;

  // observation accumulators
  logic [31:0]  rx_seq;
  int           n_valid;
  int           n_fe;
  int           tick_no;
  int           vld_first;
  int           vld_last;
  int           fe_pos;

  // downstream shift register fed by sOut
  logic [W-1:0] ds_q;

  piso_ser8 #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .Re        (Re),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .msb_first (msb_first),
    .en        (en),
    .sOut      (sOut),
    .sValid    (sValid),
    .frame_end (frame_end),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sValid === 1'b1) ds_q <= {ds_q[W-2:0], sOut};
  end

  function automatic logic model_bit();
    logic [W-1:0] w;
    w = q_word[0];
    return q_msb[0] ? w[W-1-head_idx] : w[head_idx];
  endfunction

  task automatic clear_obs();
    rx_seq    = '0;
    n_valid   = 0;
    n_fe      = 0;
    vld_first = -1;
    vld_last  = -1;
    fe_pos    = -1;
  endtask

  task automatic model_reset();
    q_word.delete();
    q_msb.delete();
    head_idx = 0;
  endtask

  // One clock cycle: drive inputs just after a falling edge, compare outputs
  // to the model, then advance the model across the rising edge.
  task automatic tick(input logic v, input logic [W-1:0] d, input logic m,
                      input logic e);
    logic exp_busy, exp_ready, exp_vld, exp_fe, exp_sout, acc;
    ld_valid  = v;
    ld_data   = d;
    msb_first = m;
    en        = e;
    #1;
    exp_busy  = (q_word.size() != 0);
    exp_ready = (q_word.size() < 2);
    exp_vld   = exp_busy && e;
    exp_fe    = exp_vld && (head_idx == W - 1);
    exp_sout  = exp_busy ? model_bit() : 1'b0;

    n_cmp++;
    if (busy !== exp_busy) begin
      n_err++;
      $display("FAIL busy t=%0d: got %b want %b", tick_no, busy, exp_busy);
    end
    n_cmp++;
    if (ld_ready !== exp_ready) begin
      n_err++;
      $display("FAIL ld_ready t=%0d: got %b want %b", tick_no, ld_ready, exp_ready);
    end
    n_cmp++;
    if (sValid !== exp_vld) begin
      n_err++;
      $display("FAIL sValid t=%0d: got %b want %b", tick_no, sValid, exp_vld);
    end
    n_cmp++;
    if (frame_end !== exp_fe) begin
      n_err++;
      $display("FAIL frame_end t=%0d: got %b want %b", tick_no, frame_end, exp_fe);
    end
    n_cmp++;
    if (sOut !== exp_sout) begin
      n_err++;
      $display("FAIL sOut t=%0d: got %b want %b", tick_no, sOut, exp_sout);
    end

    if (sValid === 1'b1) begin
      rx_seq = {rx_seq[30:0], sOut};
      n_valid++;
      if (vld_first < 0) vld_first = tick_no;
      vld_last = tick_no;
      if (frame_end === 1'b1) begin
        n_fe++;
        fe_pos = n_valid;
      end
    end
    acc = v && exp_ready;

    @(posedge clk);
    if (exp_vld) begin
      head_idx++;
      if (head_idx == W) begin
        void'(q_word.pop_front());
        void'(q_msb.pop_front());
        head_idx = 0;
      end
    end
    if (acc) begin
      q_word.push_back(d);
      q_msb.push_back(m);
      n_acc++;
    end
    tick_no++;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if ({sOut, sValid, frame_end, busy, ld_ready} !== 5'b00001) begin
      n_err++;
      $display("FAIL %s: {sOut,sValid,frame_end,busy,ld_ready} got %b want 00001",
               tag, {sOut, sValid, frame_end, busy, ld_ready});
    end
  endtask

  task automatic test_reset();
    Re        = 1'b1;
    ld_valid  = 1'b0;
    ld_data   = '0;
    msb_first = 1'b0;
    en        = 1'b0;
    ds_q      = '0;
    #2 Re = 1'b0;
    #1;
    check_reset_outputs("reset_outputs");
    // An offered word must not be taken while reset is held.
    ld_valid = 1'b1;
    ld_data  = 8'h3C;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ld_valid = 1'b0;
    check_reset_outputs("reset_held");
    model_reset();
    Re = 1'b1;
  endtask

  task automatic test_msb_first();
    clear_obs();
    tick(1'b1, 8'hA5, 1'b1, 1'b1);
    repeat (W + 1) tick(1'b0, '0, 1'b0, 1'b1);
    n_cmp++;
    if (rx_seq[W-1:0] !== 8'hA5 || n_valid != W) begin
      n_err++;
      $display("FAIL msb_first_stream: got %h (%0d bits) want a5 (8 bits)",
               rx_seq[W-1:0], n_valid);
    end
    n_cmp++;
    if (n_fe != 1 || fe_pos != W) begin
      n_err++;
      $display("FAIL msb_first_frame_end: got %0d pulses at bit %0d want 1 at bit 8",
               n_fe, fe_pos);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL msb_first_busy_after: got %b want 0", busy);
    end
    n_cmp++;
    if (ds_q !== 8'hA5) begin
      n_err++;
      $display("FAIL chained_q: got %h want a5", ds_q);
    end
  endtask

  task automatic test_lsb_first();
    clear_obs();
    tick(1'b1, 8'h81, 1'b0, 1'b1);
    repeat (W + 1) tick(1'b0, '0, 1'b1, 1'b1);
    // Arrival order 1,0,0,0,0,0,0,1 packed first-bit-left.
    n_cmp++;
    if (rx_seq[W-1:0] !== 8'b1000_0001 || n_valid != W) begin
      n_err++;
      $display("FAIL lsb_first_stream: got %b (%0d bits) want 10000001 (8 bits)",
               rx_seq[W-1:0], n_valid);
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    tick(1'b1, 8'hF0, 1'b1, 1'b1);
    tick(1'b1, 8'h0F, 1'b1, 1'b1);
    n_cmp++;
    if (ld_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_ld_ready_low: got %b want 0", ld_ready);
    end
    repeat (2 * W) tick(1'b0, '0, 1'b0, 1'b1);
    n_cmp++;
    if (rx_seq[2*W-1:0] !== 16'hF00F || n_valid != 2 * W) begin
      n_err++;
      $display("FAIL b2b_stream: got %h (%0d bits) want f00f (16 bits)",
               rx_seq[2*W-1:0], n_valid);
    end
    n_cmp++;
    if (vld_last - vld_first + 1 != 2 * W) begin
      n_err++;
      $display("FAIL b2b_no_gap: got span %0d want 16", vld_last - vld_first + 1);
    end
    n_cmp++;
    if (n_fe != 2) begin
      n_err++;
      $display("FAIL b2b_frame_end_count: got %0d want 2", n_fe);
    end
  endtask

  task automatic test_stall();
    clear_obs();
    tick(1'b1, 8'hC3, 1'b1, 1'b1);
    repeat (3) tick(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b0;
      en       = 1'b0;
      #1;
      // 4th bit of 1100_0011 must sit on sOut, not marked valid.
      n_cmp++;
      if (sValid !== 1'b0 || sOut !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: sValid=%b sOut=%b want 0,0", i, sValid, sOut);
      end
      tick(1'b0, '0, 1'b0, 1'b0);
    end
    repeat (6) tick(1'b0, '0, 1'b0, 1'b1);
    n_cmp++;
    if (rx_seq[W-1:0] !== 8'hC3 || n_valid != W) begin
      n_err++;
      $display("FAIL stall_stream: got %h (%0d bits) want c3 (8 bits)",
               rx_seq[W-1:0], n_valid);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_obs();
    tick(1'b1, 8'hFF, 1'b1, 1'b1);
    repeat (4) tick(1'b0, '0, 1'b0, 1'b1);
    #2 Re = 1'b0;
    #1;
    check_reset_outputs("mid_reset_outputs");
    model_reset();
    @(negedge clk);
    Re = 1'b1;
    clear_obs();
    repeat (10) tick(1'b0, '0, 1'b0, 1'b1);
    n_cmp++;
    if (n_valid != 0) begin
      n_err++;
      $display("FAIL mid_reset_no_bits: got %0d sValid cycles want 0", n_valid);
    end
  endtask

  task automatic test_random();
    int acc0;
    logic v, e, m;
    logic [W-1:0] d;
    clear_obs();
    acc0 = n_acc;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 1) == 1);
      e = ($urandom_range(0, 3) != 0);
      m = ($urandom_range(0, 1) == 1);
      d = W'($urandom);
      tick(v, d, m, e);
    end
    repeat (3 * W) tick(1'b0, '0, 1'b0, 1'b1);
    n_cmp++;
    if (n_valid != W * (n_acc - acc0) || busy !== 1'b0) begin
      n_err++;
      $display("FAIL random_bit_total: got %0d bits busy=%b want %0d bits busy=0",
               n_valid, busy, W * (n_acc - acc0));
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    n_acc   = 0;
    tick_no = 0;
    model_reset();
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_stall();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_piso_ser8
